serial_line_rx: RTL and testbench

SERIAL_LINE_RX -- requirements
Module: serial_line_rx

---
 rtl/serial_line_rx_if.sv | 29 ++
 rtl/serial_line_rx.sv | 131 +++++++++++++
 tb/tb_serial_line_rx.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_line_rx_if.sv
// Serial receiver bundle: line input, received word handshake and error pulses.
interface serial_line_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rxd;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rxd,
    output rx_ready,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun
  );

  modport slave (
    input  rxd,
    input  rx_ready,
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun
  );
endinterface

// File: rtl/serial_line_rx.sv
// Async serial receiver, one-word output buffer. States: IDLE wait start | START check start at half bit |
// DATA sample bits at centres | STOP check stop bit | WAIT_IDLE hold after framing error until line high.
module serial_line_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8
) (
  input  logic           clk,
  input  logic           reset,
  serial_line_rx_if.slave bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  logic                 r_sync1, r_sync2;
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_ferr, r_ovr;

  state_t               w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [BIT_W-1:0]     w_bit_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_done, w_ferr, w_rxd_s, w_accept;

  assign w_rxd_s  = r_sync2;
  assign w_accept = r_valid & bus.rx_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_sync1 <= bus.rxd;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_done      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rxd_s) w_state_nxt = START;
      end
      START: begin
        if (r_cnt == HALF_TC) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = w_rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_cnt == FULL_TC) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rxd_s, r_shift[DATA_BITS-1:1]};
          if (r_bit == LAST_BIT) w_state_nxt = STOP;
          else                   w_bit_nxt   = r_bit + 1'b1;
        end
      end
      STOP: begin
        if (r_cnt == FULL_TC) begin
          w_cnt_nxt = '0;
          if (w_rxd_s) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rxd_s) w_state_nxt = IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // A completion coinciding with an accept refills the buffer instead of overrunning.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= 1'b0;
      if (w_done) begin
        if (!r_valid || w_accept) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.rx_data   = r_data;
  assign bus.rx_valid  = r_valid;
  assign bus.frame_err = r_ferr;
  assign bus.overrun   = r_ovr;
endmodule

// File: tb/tb_serial_line_rx.sv
// Directed bench for serial_line_rx: frame table plus hand-timed corner sequences.
module tb_serial_line_rx;
  localparam int CPB = 4;
  localparam int DB  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_line_rx_if #(.DATA_BITS(DB)) bus ();
  serial_line_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int       acc_tot  = 0;
  int       rise_tot = 0;
  int       ferr_tot = 0;
  int       ovr_tot  = 0;
  logic [7:0] last_acc = 8'h00;
  logic     prev_v   = 1'b0;

  always @(negedge clk) begin
    if (bus.rx_valid && bus.rx_ready) begin
      acc_tot  <= acc_tot + 1;
      last_acc <= bus.rx_data;
    end
    if (bus.rx_valid && !prev_v) rise_tot <= rise_tot + 1;
    if (bus.frame_err) ferr_tot <= ferr_tot + 1;
    if (bus.overrun)   ovr_tot  <= ovr_tot + 1;
    prev_v <= bus.rx_valid;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive_bit(input logic b);
    bus.rxd = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    drive_bit(stop_b);
  endtask

  task automatic idle(input int n);
    bus.rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"},  int'(bus.rx_data),   0);
    check({tag, "_valid"}, int'(bus.rx_valid),  0);
    check({tag, "_ferr"},  int'(bus.frame_err), 0);
    check({tag, "_ovr"},   int'(bus.overrun),   0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    int         exp_acc;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];
  int s_acc, s_rise, s_ferr, s_ovr;

  task automatic snap();
    s_acc  = acc_tot;
    s_rise = rise_tot;
    s_ferr = ferr_tot;
    s_ovr  = ovr_tot;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp_data);
    check({tag, "_acc"},  acc_tot - s_acc, 1);
    check({tag, "_data"}, int'(last_acc), int'(exp_data));
    check({tag, "_ferr"}, ferr_tot - s_ferr, 0);
    check({tag, "_ovr"},  ovr_tot - s_ovr, 0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
    vecs[1] = '{8'h3C, 1'b1, 1, 8'h3C, 0};
    vecs[2] = '{8'h00, 1'b1, 1, 8'h00, 0};
    vecs[3] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
    vecs[4] = '{8'h81, 1'b0, 0, 8'h00, 1};
    vecs[5] = '{8'h55, 1'b1, 1, 8'h55, 0};

    reset        = 1'b0;
    bus.rxd      = 1'b1;
    bus.rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(4);
    check_outputs_zero("post_reset");

    // Table: each frame sent with the consumer always ready.
    bus.rx_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      snap();
      send_frame(vecs[v].data, vecs[v].stop_b);
      idle(10);
      check($sformatf("vec%0d_acc", v),  acc_tot - s_acc,   vecs[v].exp_acc);
      check($sformatf("vec%0d_rise", v), rise_tot - s_rise, vecs[v].exp_acc);
      if (vecs[v].exp_acc > 0)
        check($sformatf("vec%0d_data", v), int'(last_acc), int'(vecs[v].exp_data));
      check($sformatf("vec%0d_ferr", v), ferr_tot - s_ferr, vecs[v].exp_ferr);
      check($sformatf("vec%0d_ovr", v),  ovr_tot - s_ovr,   0);
      check($sformatf("vec%0d_valid", v), int'(bus.rx_valid), 0);
    end

    // One-clock glitch in idle is rejected, then a real frame follows.
    snap();
    bus.rxd = 1'b0;
    @(posedge clk);
    #1;
    idle(12);
    check("glitch_rise", rise_tot - s_rise, 0);
    check("glitch_ferr", ferr_tot - s_ferr, 0);
    snap();
    send_frame(8'h3C, 1'b1);
    idle(10);
    check_frame("after_glitch", 8'h3C);

    // Latency: valid rises exactly one edge after the stop-bit window's sample point.
    bus.rx_ready = 1'b0;
    send_frame(8'h6B, 1'b1);
    check("lat_valid_early", int'(bus.rx_valid), 0);
    @(posedge clk);
    #1;
    check("lat_valid", int'(bus.rx_valid), 1);
    check("lat_data", int'(bus.rx_data), 8'h6B);
    idle(4);
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_ready = 1'b0;
    check("lat_drain", int'(bus.rx_valid), 0);
    idle(4);

    // Back-to-back with no consumer: second word overruns.
    snap();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(10);
    check("b2b_valid", int'(bus.rx_valid), 1);
    check("b2b_data", int'(bus.rx_data), 8'h11);
    check("b2b_ovr", ovr_tot - s_ovr, 1);
    check("b2b_ferr", ferr_tot - s_ferr, 0);
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_ready = 1'b0;
    @(negedge clk);
    check("b2b_cleared", int'(bus.rx_valid), 0);
    check("b2b_acc", acc_tot - s_acc, 1);
    check("b2b_acc_data", int'(last_acc), 8'h11);
    idle(4);

    // Completion in the same cycle as an accept: refill without overrun.
    send_frame(8'h5A, 1'b1);
    idle(6);
    snap();
    send_frame(8'hC3, 1'b1);
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_ready = 1'b0;
    @(negedge clk);
    check("same_valid", int'(bus.rx_valid), 1);
    check("same_data", int'(bus.rx_data), 8'hC3);
    check("same_acc_data", int'(last_acc), 8'h5A);
    idle(4);
    check("same_ovr", ovr_tot - s_ovr, 0);
    bus.rx_ready = 1'b1;
    idle(2);
    check("same_drain_data", int'(last_acc), 8'hC3);
    check("same_drain_valid", int'(bus.rx_valid), 0);

    // Reset mid-frame after three data bits of 0xF0.
    snap();
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    bus.rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    check_outputs_zero("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("mid_reset_hold");
    reset = 1'b1;
    idle(4);
    check("mid_rel_rise", rise_tot - s_rise, 0);
    check("mid_rel_ferr", ferr_tot - s_ferr, 0);
    check("mid_rel_ovr", ovr_tot - s_ovr, 0);
    snap();
    send_frame(8'h0F, 1'b1);
    idle(10);
    check_frame("after_reset", 8'h0F);

    // Break: line low for 40 clocks yields exactly one framing error.
    snap();
    bus.rxd = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    idle(20);
    check("break_ferr", ferr_tot - s_ferr, 1);
    check("break_rise", rise_tot - s_rise, 0);
    snap();
    send_frame(8'h99, 1'b1);
    idle(10);
    check_frame("after_break", 8'h99);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
